// File: rtl/imem_rw_arbiter.sv
// Shares the instruction memory rw port between the core data bus and a byte-stream
// program loader; the loader owns the port (and holds the core in reset) while busy.
module imem_rw_arbiter #(
  parameter  int DEPTH = 4096,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [31:0]   core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [31:0]   core_rdata,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_base,
  input  logic          ld_byte_valid,
  input  logic [7:0]    ld_byte,
  output logic          ld_byte_ready,
  input  logic          ld_end,
  output logic          ld_busy,
  output logic          ld_done,
  output logic [AW-1:0] ld_words,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] r_words;
  logic [1:0]    r_cnt;
  logic [23:0]   r_asm;
  logic [31:0]   r_pend;
  logic          r_pend_valid;
  logic          r_rvalid;

  logic          w_gnt;
  logic          w_ready;
  logic          w_wr;
  logic          w_done;
  logic          w_accept;
  logic [31:0]   w_wdata;
  logic [31:0]   w_partial;
  logic [AW-1:0] w_base_aligned;

  assign w_base_aligned = ld_base & ~AW'(3);
  assign w_accept       = w_ready && ld_byte_valid;

  // Partial word for the session tail: only the bytes actually received, high bytes zero.
  always_comb begin
    w_partial = '0;
    case (r_cnt)
      2'd1:    w_partial = {24'h0, r_asm[7:0]};
      2'd2:    w_partial = {16'h0, r_asm[15:0]};
      2'd3:    w_partial = {8'h0, r_asm};
      default: w_partial = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = 1'b0;
    w_ready     = 1'b0;
    w_wr        = 1'b0;
    w_done      = 1'b0;
    w_wdata     = r_pend;
    case (r_state)
      IDLE: begin
        w_gnt = core_req && !ld_start;
        if (ld_start) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_ready = 1'b1;
        w_wr    = r_pend_valid;
        if (ld_end) w_state_nxt = FINISH;
      end
      FINISH: begin
        // Drain the pending word first, then the partial word, then signal done.
        if (r_pend_valid) begin
          w_wr = 1'b1;
          if (r_cnt == 2'd0) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          w_wr        = (r_cnt != 2'd0);
          w_wdata     = w_partial;
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (rst) begin
      w_state_nxt = IDLE;
      w_gnt       = 1'b0;
      w_ready     = 1'b0;
      w_wr        = 1'b0;
      w_done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_words      <= '0;
      r_cnt        <= 2'd0;
      r_asm        <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_rvalid     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rvalid <= w_gnt && !core_we;
      if (r_state == IDLE && ld_start) begin
        r_ptr        <= w_base_aligned;
        r_words      <= '0;
        r_cnt        <= 2'd0;
        r_pend_valid <= 1'b0;
      end else begin
        if (w_wr) begin
          r_ptr <= r_ptr + AW'(4);
          if (r_words != '1) r_words <= r_words + AW'(1);
        end
        if (w_wr && r_pend_valid) r_pend_valid <= 1'b0;
        if (r_state == FINISH && !r_pend_valid) r_cnt <= 2'd0;
        // The 4th byte bypasses the assembly register straight into the pending word.
        if (w_accept) begin
          if (r_cnt == 2'd3) begin
            r_pend       <= {ld_byte, r_asm};
            r_pend_valid <= 1'b1;
            r_cnt        <= 2'd0;
          end else begin
            r_asm[{r_cnt, 3'b000} +: 8] <= ld_byte;
            r_cnt                       <= r_cnt + 2'd1;
          end
        end
      end
    end
  end

  assign core_gnt      = w_gnt;
  assign core_rvalid   = r_rvalid;
  assign core_rdata    = mem_rdata;
  assign ld_byte_ready = w_ready;
  assign ld_busy       = (r_state != IDLE) && !rst;
  assign ld_done       = w_done;
  assign ld_words      = r_words;
  assign mem_we        = w_wr || (w_gnt && core_we);
  assign mem_addr      = (r_state == IDLE) ? core_addr  : r_ptr;
  assign mem_wdata     = (r_state == IDLE) ? core_wdata : w_wdata;

endmodule

// File: tb/tb_imem_rw_arbiter.sv
// Scoreboard bench for imem_rw_arbiter: a behavioural memory, queues of expected
// loader writes and core read data, and one task per scenario.
module tb_imem_rw_arbiter;
  localparam int DEPTH = 4096;
  localparam int AW    = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req, core_we;
  logic [AW-1:0] core_addr;
  logic [31:0]   core_wdata;
  logic          core_gnt, core_rvalid;
  logic [31:0]   core_rdata;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic          ld_byte_valid;
  logic [7:0]    ld_byte;
  logic          ld_byte_ready, ld_end, ld_busy, ld_done;
  logic [AW-1:0] ld_words;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         wrQ[$];
  logic [31:0] rdQ[$];
  logic [7:0]  streamQ[$];
  logic [31:0] tbMem[DEPTH/4];

  int checks   = 0;
  int fails    = 0;
  int doneSeen = 0;

  imem_rw_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .ld_start(ld_start), .ld_base(ld_base), .ld_byte_valid(ld_byte_valid),
    .ld_byte(ld_byte), .ld_byte_ready(ld_byte_ready), .ld_end(ld_end),
    .ld_busy(ld_busy), .ld_done(ld_done), .ld_words(ld_words),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) tbMem[mem_addr[AW-1:2]] <= mem_wdata;
    mem_rdata <= tbMem[mem_addr[AW-1:2]];
  end

  // Scoreboard: every loader write and every core read return is matched in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we && ld_busy) begin
        checks++;
        if (wrQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_write: got addr %h data %h, required no write", mem_addr, mem_wdata);
        end else begin
          wr_t exp;
          exp = wrQ.pop_front();
          if (mem_addr !== exp.addr || mem_wdata !== exp.data) begin
            fails++;
            $display("[TB] FAIL ld_write: got %h@%h, required %h@%h", mem_wdata, mem_addr, exp.data, exp.addr);
          end
        end
      end
      if (core_rvalid) begin
        checks++;
        if (rdQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_rvalid: got rdata %h, required no rvalid", core_rdata);
        end else begin
          logic [31:0] expR;
          expR = rdQ.pop_front();
          if (core_rdata !== expR) begin
            fails++;
            $display("[TB] FAIL core_rdata: got %h, required %h", core_rdata, expR);
          end
        end
      end
      if (ld_done) doneSeen++;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pushWr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wrQ.push_back(w);
  endtask

  // mode 0: ld_end after the last byte, 1: ld_end with the last byte, 2: no ld_end
  task automatic streamBytes(input int mode);
    for (int i = 0; i < streamQ.size(); i++) begin
      ld_byte_valid = 1'b1;
      ld_byte       = streamQ[i];
      ld_end        = (mode == 1) && (i == streamQ.size() - 1);
      tick();
    end
    ld_byte_valid = 1'b0;
    ld_end        = 1'b0;
    if (mode == 0) begin
      ld_end = 1'b1;
      tick();
      ld_end = 1'b0;
    end
  endtask

  task automatic startLoad(input logic [AW-1:0] base);
    ld_start = 1'b1;
    ld_base  = base;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; core_req = 1'b1; core_we = 1'b0; ld_byte_valid = 1'b1; ld_byte = 8'h5A;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (core_gnt !== 1'b0)    begin fails++; $display("[TB] FAIL rst_gnt: got %b, required 0", core_gnt); end
    checks++; if (core_rvalid !== 1'b0) begin fails++; $display("[TB] FAIL rst_rvalid: got %b, required 0", core_rvalid); end
    checks++; if (ld_byte_ready !== 1'b0) begin fails++; $display("[TB] FAIL rst_ready: got %b, required 0", ld_byte_ready); end
    checks++; if (ld_busy !== 1'b0)     begin fails++; $display("[TB] FAIL rst_busy: got %b, required 0", ld_busy); end
    checks++; if (ld_done !== 1'b0)     begin fails++; $display("[TB] FAIL rst_done: got %b, required 0", ld_done); end
    checks++; if (ld_words !== '0)      begin fails++; $display("[TB] FAIL rst_words: got %h, required 0", ld_words); end
    checks++; if (mem_we !== 1'b0)      begin fails++; $display("[TB] FAIL rst_mem_we: got %b, required 0", mem_we); end
    rst = 1'b0; core_req = 1'b0; ld_byte_valid = 1'b0;
    tick();
  endtask

  task automatic test_core_access;
    core_req = 1'b1; core_we = 1'b1; core_addr = 12'h010; core_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (core_gnt !== 1'b1) begin fails++; $display("[TB] FAIL wr_gnt: got %b, required 1", core_gnt); end
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 12'h010 || mem_wdata !== 32'hDEADBEEF) begin
      fails++; $display("[TB] FAIL wr_port: got we %b %h@%h, required 1 deadbeef@010", mem_we, mem_wdata, mem_addr);
    end
    tick();
    core_we = 1'b0;
    rdQ.push_back(32'hDEADBEEF);
    @(negedge clk);
    checks++; if (core_gnt !== 1'b1 || mem_we !== 1'b0) begin fails++; $display("[TB] FAIL rd_gnt: got gnt %b we %b, required 1 0", core_gnt, mem_we); end
    checks++; if (core_rvalid !== 1'b0) begin fails++; $display("[TB] FAIL rd_early: got rvalid %b, required 0", core_rvalid); end
    tick();
    core_req = 1'b0;
    @(negedge clk);
    checks++; if (core_rvalid !== 1'b1) begin fails++; $display("[TB] FAIL rd_latency: got rvalid %b, required 1", core_rvalid); end
    tick();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      core_req = 1'b1; core_we = 1'b1;
      core_addr = AW'(32'h20 + 4 * i); core_wdata = 32'hA5A50000 + 32'(i * 7);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      core_we = 1'b0; core_addr = AW'(32'h20 + 4 * i);
      rdQ.push_back(32'hA5A50000 + 32'(i * 7));
      @(negedge clk);
      if (i > 0) begin
        checks++; if (core_rvalid !== 1'b1) begin fails++; $display("[TB] FAIL b2b_rvalid: got %b, required 1", core_rvalid); end
      end
      tick();
    end
    core_req = 1'b0;
    repeat (2) tick();
    checks++; if (rdQ.size() != 0) begin fails++; $display("[TB] FAIL b2b_drain: got %0d reads left, required 0", rdQ.size()); end
  endtask

  task automatic test_load;
    doneSeen = 0;
    pushWr(12'h100, 32'h44332211);
    pushWr(12'h104, 32'h88776655);
    startLoad(12'h102);
    @(negedge clk);
    checks++; if (ld_busy !== 1'b1 || ld_words !== '0) begin fails++; $display("[TB] FAIL load_start: got busy %b words %h, required 1 0", ld_busy, ld_words); end
    checks++; if (ld_byte_ready !== 1'b1) begin fails++; $display("[TB] FAIL load_ready: got %b, required 1", ld_byte_ready); end
    streamQ = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 8; i++) begin
      ld_byte_valid = 1'b1; ld_byte = streamQ[i];
      tick();
    end
    ld_byte_valid = 1'b0; ld_end = 1'b1;
    @(negedge clk);
    checks++; if (ld_busy !== 1'b1 || ld_words !== 12'd1) begin fails++; $display("[TB] FAIL load_mid: got busy %b words %h, required 1 1", ld_busy, ld_words); end
    tick();
    ld_end = 1'b0;
    repeat (5) tick();
    checks++; if (doneSeen != 1) begin fails++; $display("[TB] FAIL load_done: got %0d pulses, required 1", doneSeen); end
    checks++; if (ld_words !== 12'd2 || ld_busy !== 1'b0) begin fails++; $display("[TB] FAIL load_end: got words %h busy %b, required 2 0", ld_words, ld_busy); end
    checks++; if (wrQ.size() != 0) begin fails++; $display("[TB] FAIL load_writes: got %0d missing, required 0", wrQ.size()); end
  endtask

  task automatic test_partial;
    doneSeen = 0;
    pushWr(12'h200, 32'hDDCCBBAA);
    pushWr(12'h204, 32'h000000EE);
    startLoad(12'h200);
    streamQ = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    streamBytes(1);
    @(negedge clk);
    checks++; if (ld_done !== 1'b1 || mem_we !== 1'b1) begin fails++; $display("[TB] FAIL partial_done: got done %b we %b, required 1 1", ld_done, mem_we); end
    repeat (4) tick();
    checks++; if (doneSeen != 1 || ld_words !== 12'd2) begin fails++; $display("[TB] FAIL partial_end: got done %0d words %h, required 1 2", doneSeen, ld_words); end
    checks++; if (wrQ.size() != 0) begin fails++; $display("[TB] FAIL partial_writes: got %0d missing, required 0", wrQ.size()); end
  endtask

  task automatic test_arbitration;
    core_req = 1'b1; core_we = 1'b0; core_addr = 12'h010;
    ld_start = 1'b1; ld_base = 12'h300;
    @(negedge clk);
    checks++; if (core_gnt !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("[TB] FAIL arb_start: got gnt %b we %b, required 0 0", core_gnt, mem_we); end
    tick();
    ld_start = 1'b0;
    @(negedge clk);
    checks++; if (ld_busy !== 1'b1 || core_gnt !== 1'b0 || core_rvalid !== 1'b0) begin
      fails++; $display("[TB] FAIL arb_load: got busy %b gnt %b rvalid %b, required 1 0 0", ld_busy, core_gnt, core_rvalid);
    end
    pushWr(12'h300, 32'h04030201);
    streamQ = '{8'h01, 8'h02, 8'h03, 8'h04};
    streamBytes(0);
    @(negedge clk);
    checks++; if (core_gnt !== 1'b0 || ld_busy !== 1'b1 || ld_done !== 1'b1) begin
      fails++; $display("[TB] FAIL arb_finish: got gnt %b busy %b done %b, required 0 1 1", core_gnt, ld_busy, ld_done);
    end
    tick();
    rdQ.push_back(32'hDEADBEEF);
    @(negedge clk);
    checks++; if (core_gnt !== 1'b1) begin fails++; $display("[TB] FAIL arb_idle: got gnt %b, required 1", core_gnt); end
    tick();
    core_req = 1'b0;
    repeat (2) tick();
    checks++; if (rdQ.size() != 0 || wrQ.size() != 0) begin fails++; $display("[TB] FAIL arb_drain: got rd %0d wr %0d left, required 0 0", rdQ.size(), wrQ.size()); end
  endtask

  task automatic test_wrap;
    pushWr(12'hFFC, 32'h04030201);
    pushWr(12'h000, 32'h08070605);
    startLoad(AW'(DEPTH - 4));
    streamQ = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    streamBytes(0);
    repeat (4) tick();
    checks++; if (ld_words !== 12'd2 || wrQ.size() != 0) begin fails++; $display("[TB] FAIL wrap: got words %h missing %0d, required 2 0", ld_words, wrQ.size()); end
  endtask

  task automatic test_abort;
    int nBytes[2];
    nBytes = '{2, 4};
    for (int k = 0; k < 2; k++) begin
      doneSeen = 0;
      startLoad(12'h400);
      streamQ = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
      streamQ = streamQ[0:nBytes[k]-1];
      streamBytes(2);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (mem_we !== 1'b0) begin fails++; $display("[TB] FAIL abort_rst_we: got %b, required 0", mem_we); end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        checks++; if (mem_we !== 1'b0) begin fails++; $display("[TB] FAIL abort_we: got %b, required 0", mem_we); end
        tick();
      end
      checks++; if (ld_busy !== 1'b0 || ld_words !== '0 || doneSeen != 0) begin
        fails++; $display("[TB] FAIL abort_state: got busy %b words %h done %0d, required 0 0 0", ld_busy, ld_words, doneSeen);
      end
    end
  endtask

  initial begin
    rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    ld_start = 1'b0; ld_base = '0; ld_byte_valid = 1'b0; ld_byte = '0; ld_end = 1'b0;
    test_reset();
    test_core_access();
    test_back_to_back();
    test_load();
    test_partial();
    test_arbitration();
    test_wrap();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/imem_rw_arbiter.md
# imem_rw_arbiter

Controller for the instruction memory's synchronous read/write port. It shares that port between two requesters. The first is the core's data bus, for load/store accesses into the instruction region. The second is a byte-stream program loader (UART/debug side), which assembles little-endian words and writes them sequentially from a base address. While a load is in progress the core is held off the port and kept in reset. The fetch (read-only) port is not touched by this block.

## Interface

Parameters:
- DEPTH, 4096, instruction memory size; AW = $clog2(DEPTH) is the byte-address width, matching the memory's address ports

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- core_req  in  1  core requests the rw port this cycle
- core_we  in  1  1 = write, 0 = read
- core_addr  in  AW  byte address; passed to memory unchanged (memory ignores bits [1:0])
- core_wdata  in  32  write data
- core_gnt  out  1  request accepted this cycle (combinational)
- core_rvalid  out  1  read data valid, registered
- core_rdata  out  32  read data (mem_rdata pass-through), meaningful only when core_rvalid=1
- ld_start  in  1  one-cycle pulse that opens a load session
- ld_base  in  AW  session start byte address, sampled on ld_start
- ld_byte_valid  in  1  loader byte valid
- ld_byte  in  8  loader byte
- ld_byte_ready  out  1  byte accepted when valid && ready
- ld_end  in  1  one-cycle pulse that closes the session
- ld_busy  out  1  session active; also drives the core reset hold
- ld_done  out  1  one-cycle pulse when the session's last write completes
- ld_words  out  AW  count of words written in the current/last session
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory rw address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data; valid one cycle after a read address is presented

## Operation

- States: IDLE, LOAD, FINISH.
- **IDLE**
  - core_gnt = core_req && !ld_start.
  - On grant: mem_addr = core_addr, mem_we = core_we, mem_wdata = core_wdata.
  - A granted read sets core_rvalid in the next cycle.
  - ld_start has priority over core_req in the same cycle: the core is not granted, and the state goes to LOAD.
- **ld_start (in IDLE)**
  - ptr <= ld_base & ~3
  - byte count cnt <= 0
  - ld_words <= 0
  - ld_start outside IDLE is ignored.
- **LOAD**
  - ld_byte_ready = 1 and core_gnt = 0.
  - Accepted bytes fill the assembly register LSB-first: byte cnt goes to bits [8*cnt+7 : 8*cnt].
  - When the 4th byte is accepted:
    - the full word moves to a pending register, cnt <= 0;
    - in the next cycle: mem_we = 1, mem_addr = ptr, mem_wdata = pending; ptr += 4; ld_words += 1.
  - Byte acceptance continues during that write cycle.
- **ld_end (in LOAD)**
  - A byte accepted in the same cycle counts first; then the state goes to FINISH.
  - ld_end outside LOAD is ignored.
- **FINISH**
  - ld_byte_ready = 0.
  - Remaining writes are issued one per cycle, in order:
    - the pending full word (if any);
    - then the partial word (if cnt > 0), with unfilled high bytes zero, at ptr.
  - Each write advances ptr and ld_words.
  - After the last write (or immediately if none remain): ld_done pulses and the state goes to IDLE.
- **Pointer arithmetic:** ptr is AW bits and wraps modulo DEPTH. ld_words saturates at all-ones.
- **ld_busy** = 1 in LOAD and FINISH.
- **mem_we** is 0 whenever no write is being issued. mem_addr/mem_wdata are don't-care when mem_we = 0 and no read is granted.

## Timing

- **Reset values:**
  - state = IDLE
  - core_gnt = 0 (comb; no core_req during reset is granted)
  - core_rvalid = 0
  - ld_byte_ready = 0
  - ld_busy = 0
  - ld_done = 0
  - ld_words = 0
  - mem_we = 0
  - ptr = 0, cnt = 0, pending flag clear
- **Reset mid-session:** the partial word and pending word are discarded, and no write is issued in the cycle after reset deasserts.
- **Core read latency:** grant in cycle N, core_rvalid = 1 with data in cycle N+1. Back-to-back reads can issue every cycle.
- **Core write:** takes effect in the grant cycle.
- **Loader write latency:** 1 cycle after the 4th byte is accepted. Sustained throughput is 1 byte/cycle with no stalls.
- **ld_end to ld_done:** the cycle after ld_end is the first FINISH cycle.
  - No remaining writes: ld_done asserts in that first FINISH cycle and the state is IDLE in the next cycle.
  - k remaining writes (k ≤ 2): ld_done asserts in the cycle of the k-th write; IDLE follows.
- A read granted in the cycle that ld_start is seen cannot occur (ld_start wins).
- A read granted in the cycle before ld_start still returns core_rvalid normally.

## Test plan

- **Reset:** hold rst with core_req = 1, ld_byte_valid = 1 → all outputs at reset values, no mem_we, no grant.
- **Core access:** write 0xDEADBEEF to 0x010, read 0x010 in the next cycle → core_gnt in the same cycle; core_rvalid one cycle later, core_rdata = 0xDEADBEEF.
- **Load:**
  - Stimulus: ld_start with base 0x102, stream bytes 11 22 33 44 55 66 77 88 back-to-back, then ld_end.
  - Required: writes 0x44332211 @0x100 and 0x88776655 @0x104; ld_words = 2; ld_done one pulse; ld_busy high start to end.
- **Partial and coincident end:**
  - Stimulus: stream AA BB CC DD EE, with ld_end in the same cycle as EE.
  - Required: 0xDDCCBBAA then 0x000000EE at consecutive addresses; ld_words = 2.
- **Arbitration:** core_req and ld_start in the same cycle → core_gnt = 0, state LOAD. core_req during LOAD → never granted until IDLE.
- **Wrap and abort:**
  - Base DEPTH-4 with 8 bytes → the second word is written at 0x000.
  - Separate run: assert rst after 2 bytes → no write ever issued, ld_busy = 0.
